// File: rtl/fc_layer_stream_if.sv
// Stream interface of the fully-connected layer: activation/weight input
// stream and serial class-score output stream.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid && ready are both high. The producer keeps data stable while
// valid && !ready, and never waits for ready before raising valid. The
// consumer may raise ready independently of valid.
interface fc_layer_stream_if #(
  parameter int IN_WIDTH     = 45,
  parameter int WEIGHT_WIDTH = 32,
  parameter int N_OUT        = 10,
  parameter int OUT_WIDTH    = 32
);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [IN_WIDTH-1:0]           in_data;
  logic [N_OUT*WEIGHT_WIDTH-1:0] in_weights;

  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_WIDTH-1:0]          out_data;
  logic [IDX_W-1:0]              out_idx;
  logic                          out_last;

  // Producer of activations / consumer of scores (pooling + classifier side).
  modport master (
    output in_valid, in_data, in_weights, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // The FC layer itself.
  modport slave (
    input  in_valid, in_data, in_weights, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/fc_layer_stream.sv
// Sequential fully-connected layer. One activation plus its N_OUT weights per
// accepted beat; N_OUT signed dot products accumulate in parallel through a
// one-stage product register, then each score is shifted, saturated,
// optionally ReLU-clamped and emitted serially.
module fc_layer_stream #(
  parameter int IN_WIDTH     = 45,
  parameter int WEIGHT_WIDTH = 32,
  parameter int N_IN         = 1152,
  parameter int N_OUT        = 10,
  parameter int ACC_WIDTH    = 96,
  parameter int SHIFT        = 0,
  parameter int OUT_WIDTH    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              relu_en,
  fc_layer_stream_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int PROD_W = IN_WIDTH + 1 + WEIGHT_WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_IN);

  // Saturation bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic                         relu_q;
  logic                         prod_vld;
  logic signed [PROD_W-1:0]     prod    [N_OUT];
  logic signed [ACC_WIDTH-1:0]  acc     [N_OUT];
  logic signed [ACC_WIDTH-1:0]  acc_nxt [N_OUT];
  logic                         start_acc;
  logic                         beat_acc;
  logic                         out_hs;
  logic                         is_last;
  logic [IDX_W-1:0]             sel_idx;

  // Shift, saturate to the output range, then optional ReLU clamp.
  function automatic logic [OUT_WIDTH-1:0] score_f(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic                        relu
  );
    logic signed [ACC_WIDTH-1:0] t;
    logic [OUT_WIDTH-1:0]        r;
    t = a >>> SHIFT;
    if (t > SAT_MAX)      r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (t < SAT_MIN) r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                  r = t[OUT_WIDTH-1:0];
    if (relu && r[OUT_WIDTH-1]) r = '0;
    return r;
  endfunction

  // A start landing on the done cycle is deliberately refused.
  assign start_acc = (state == S_IDLE) && start && !done;
  assign beat_acc  = bus.in_valid && bus.in_ready;
  assign out_hs    = bus.out_valid && bus.out_ready;
  assign is_last   = (bus.out_idx == LAST_IDX);
  // Index of the score to preload after a handshake; wraps to 0 on the last
  // one so the array is never indexed out of range.
  assign sel_idx   = is_last ? '0 : bus.out_idx + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs. The last beat moves straight to
  // DRAIN so the first score is valid two cycles after that beat.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    busy          = (state != S_IDLE);
    state_dbg     = state;
    case (state)
      S_IDLE: begin
        if (start_acc) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        bus.in_ready = (cnt < FULL_CNT);
        if (beat_acc && (cnt == LAST_CNT)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = is_last;
        if (out_hs && is_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator values after absorbing the registered product, if any.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      acc_nxt[k] = acc[k];
      if (prod_vld) acc_nxt[k] = acc[k] + ACC_WIDTH'(prod[k]);
    end
  end

  // Beat counter and relu flag captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      relu_q <= 1'b0;
    end else if (start_acc) begin
      cnt    <= '0;
      relu_q <= relu_en;
    end else if (beat_acc) begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Stage 1: products of the accepted beat; bubbles register nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      for (int k = 0; k < N_OUT; k++) prod[k] <= '0;
    end else begin
      prod_vld <= beat_acc;
      if (beat_acc) begin
        for (int k = 0; k < N_OUT; k++)
          prod[k] <= PROD_W'($signed({1'b0, bus.in_data})) *
                     PROD_W'($signed(bus.in_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      end
    end
  end

  // Stage 2: wrapping two's-complement accumulation, cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else if (start_acc) begin
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) acc[k] <= acc_nxt[k];
    end
  end

  // Registered score/index: preload neuron 0 from the final sums in DRAIN,
  // advance on each handshake, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_idx  <= '0;
    end else if (state == S_DRAIN) begin
      bus.out_data <= score_f(acc_nxt[0], relu_q);
      bus.out_idx  <= '0;
    end else if ((state == S_OUTPUT) && out_hs) begin
      if (is_last) begin
        bus.out_data <= '0;
        bus.out_idx  <= '0;
      end else begin
        bus.out_data <= score_f(acc[sel_idx], relu_q);
        bus.out_idx  <= sel_idx;
      end
    end
  end

  // One-cycle completion pulse following the last score handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == S_OUTPUT) && out_hs && is_last;
  end

endmodule
